// File: rtl/ser2par.sv
// Serial-to-parallel deserializer: collects data_serial bits into WIDTH-bit words
// and presents each completed word through a one-deep ready/valid holding register.
module ser2par #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1,
   localparam int CW       = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             data_serial,
   input  logic             data_valid,
   input  logic             flush,
   input  logic             clr_overrun,
   input  logic             par_ready,
   output logic [WIDTH-1:0] data_parallel,
   output logic             par_valid,
   output logic             overrun,
   output logic [CW-1:0]    bit_count
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_t;

   out_state_t       state;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] sr_next;
   logic             take_bit;
   logic             complete;

   // Handshake: a word transfers on a rising edge where par_valid=1 and par_ready=1;
   // data_parallel is stable while par_valid=1 and par_ready has no effect while EMPTY.
   assign par_valid = (state == FULL);

   assign take_bit = data_valid && !flush;
   assign complete = take_bit && (bit_count == CW'(WIDTH - 1));

   always_comb begin
      sr_next = sr;
      if (MSB_FIRST) sr_next = {sr[WIDTH-2:0], data_serial};
      else           sr_next = {data_serial, sr[WIDTH-1:1]};
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sr            <= '0;
         bit_count     <= '0;
         data_parallel <= '0;
         overrun       <= 1'b0;
         state         <= EMPTY;
      end else begin
         if (flush) begin
            sr        <= '0;
            bit_count <= '0;
         end else if (data_valid) begin
            sr        <= sr_next;
            bit_count <= complete ? '0 : bit_count + CW'(1);
         end

         // Clear first so a same-cycle drop below takes precedence.
         if (clr_overrun) overrun <= 1'b0;

         case (state)
            EMPTY: begin
               if (complete) begin
                  data_parallel <= sr_next;
                  state         <= FULL;
               end
            end
            FULL: begin
               if (complete) begin
                  if (par_ready) data_parallel <= sr_next;
                  else           overrun       <= 1'b1;
               end else if (par_ready) begin
                  state <= EMPTY;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_ser2par.sv
// Bench for ser2par: MSB-first and LSB-first instances share stimulus; a bit-queue
// reference model feeds per-instance expected-word queues drained by a monitor.
module tb_ser2par;
   localparam int WIDTH = 4;
   localparam int CW    = $clog2(WIDTH + 1);

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             data_serial = 1'b0;
   logic             data_valid = 1'b0;
   logic             flush = 1'b0;
   logic             clr_overrun = 1'b0;
   logic             par_ready = 1'b0;
   logic [WIDTH-1:0] dp_msb, dp_lsb;
   logic             pv_msb, pv_lsb;
   logic             ov_msb, ov_lsb;
   logic [CW-1:0]    bc_msb, bc_lsb;

   ser2par #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .reset_n(reset_n), .data_serial(data_serial), .data_valid(data_valid),
      .flush(flush), .clr_overrun(clr_overrun), .par_ready(par_ready),
      .data_parallel(dp_msb), .par_valid(pv_msb), .overrun(ov_msb), .bit_count(bc_msb)
   );

   ser2par #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .reset_n(reset_n), .data_serial(data_serial), .data_valid(data_valid),
      .flush(flush), .clr_overrun(clr_overrun), .par_ready(par_ready),
      .data_parallel(dp_lsb), .par_valid(pv_lsb), .overrun(ov_lsb), .bit_count(bc_lsb)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic             bits_q[$];
   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] exp_q_lsb[$];
   logic             m_full = 1'b0;
   logic             m_ovr  = 1'b0;

   int n_vec = 0;
   int n_miss = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops an expected word whenever a transfer handshake is presented.
   always @(negedge clk) begin
      if (reset_n) begin
         if (pv_msb && par_ready) begin
            if (exp_q.size() == 0) chk("msb_unexpected_word", 32'(dp_msb), 32'hdead);
            else                   chk("msb_word", 32'(dp_msb), 32'(exp_q.pop_front()));
         end
         if (pv_lsb && par_ready) begin
            if (exp_q_lsb.size() == 0) chk("lsb_unexpected_word", 32'(dp_lsb), 32'hdead);
            else                       chk("lsb_word", 32'(dp_lsb), 32'(exp_q_lsb.pop_front()));
         end
      end
   end

   // Apply one cycle of inputs, advance the model, then check status after the edge.
   task automatic step(input logic d, input logic v, input logic fl, input logic clr,
                       input logic rdy, input logic rst);
      logic             comp;
      logic [WIDTH-1:0] w_msb, w_lsb;
      data_serial = d;
      data_valid  = v;
      flush       = fl;
      clr_overrun = clr;
      par_ready   = rdy;
      reset_n     = !rst;
      comp  = 1'b0;
      w_msb = '0;
      w_lsb = '0;
      if (rst) begin
         bits_q.delete();
         exp_q.delete();
         exp_q_lsb.delete();
         m_full = 1'b0;
         m_ovr  = 1'b0;
      end else begin
         if (fl) bits_q.delete();
         else if (v) begin
            bits_q.push_back(d);
            if (bits_q.size() == WIDTH) begin
               comp = 1'b1;
               for (int i = 0; i < WIDTH; i++) begin
                  w_msb[WIDTH-1-i] = bits_q[i];
                  w_lsb[i]         = bits_q[i];
               end
               bits_q.delete();
            end
         end
         if (clr) m_ovr = 1'b0;
         if (comp) begin
            if (!m_full || rdy) begin
               exp_q.push_back(w_msb);
               exp_q_lsb.push_back(w_lsb);
               m_full = 1'b1;
            end else begin
               m_ovr = 1'b1;
            end
         end else if (m_full && rdy) begin
            m_full = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      chk("msb_par_valid", 32'(pv_msb), 32'(m_full));
      chk("msb_overrun",   32'(ov_msb), 32'(m_ovr));
      chk("msb_bit_count", 32'(bc_msb), 32'(bits_q.size()));
      chk("lsb_par_valid", 32'(pv_lsb), 32'(m_full));
      chk("lsb_overrun",   32'(ov_lsb), 32'(m_ovr));
      chk("lsb_bit_count", 32'(bc_lsb), 32'(bits_q.size()));
   endtask

   task automatic send_word(input logic [WIDTH-1:0] w, input logic rdy, input int gap);
      for (int i = WIDTH - 1; i >= 0; i--) begin
         step(w[i], 1'b1, 1'b0, 1'b0, rdy, 1'b0);
         for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
      end
   endtask

   task automatic idle(input logic rdy, input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
   endtask

   initial begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("reset_data_msb", 32'(dp_msb), 32'h0);
      chk("reset_data_lsb", 32'(dp_lsb), 32'h0);

      // Back-to-back bits with a ready consumer
      send_word(4'hB, 1'b1, 0);
      chk("t1_word_b", 32'(dp_msb), 32'hB);
      idle(1'b1, 2);

      // Idle gaps between bits
      send_word(4'hC, 1'b1, 2);
      chk("t2_word_c", 32'(dp_msb), 32'hC);
      idle(1'b1, 2);

      // Backpressure loses the second word
      send_word(4'hA, 1'b0, 0);
      send_word(4'h5, 1'b0, 0);
      chk("t3_held_a", 32'(dp_msb), 32'hA);
      chk("t3_overrun", 32'(ov_msb), 32'h1);
      idle(1'b1, 1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("t3_overrun_clr", 32'(ov_msb), 32'h0);

      // Consume and reload on the same edge
      send_word(4'h3, 1'b0, 0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("t4_word_9", 32'(dp_msb), 32'h9);
      idle(1'b1, 2);

      // Flush drops the partial word and the bit presented with it
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      send_word(4'h6, 1'b1, 0);
      chk("t5_word_6", 32'(dp_msb), 32'h6);
      idle(1'b1, 1);

      // Reset mid-word and with a held word
      send_word(4'h7, 1'b0, 0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("t5_reset_data", 32'(dp_msb), 32'h0);
      chk("t5_reset_count", 32'(bc_msb), 32'h0);

      // LSB-first mapping
      send_word(4'h8, 1'b0, 0);
      chk("t6_lsb_word_1", 32'(dp_lsb), 32'h1);
      idle(1'b1, 1);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         step(1'($urandom_range(0, 1)),
              ($urandom_range(0, 99) < 70),
              ($urandom_range(0, 99) < 4),
              ($urandom_range(0, 99) < 5),
              ($urandom_range(0, 99) < 55),
              ($urandom_range(0, 999) < 5));
      end

      idle(1'b1, 4);
      chk("drain_msb", 32'(exp_q.size()), 32'h0);
      chk("drain_lsb", 32'(exp_q_lsb.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
